// File: rtl/dram_load_scheduler.sv
// Round-robin scheduler sharing one DRAM read stream and one packer between
// several on-chip memory banks; converts packer write levels into bank strobes.
module dram_load_scheduler #(
  parameter int NUM_BANKS          = 3,
  parameter int DRAM_ADDR_BITWIDTH = 32,
  parameter int ADDR_BITWIDTH      = 10,
  parameter int BEATS_PER_WORD     = 21,
  parameter int BEAT_BITWIDTH      = ADDR_BITWIDTH + $clog2(BEATS_PER_WORD) + 1
) (
  input  logic                                   clk_i,
  input  logic                                   dram_sched_rst_i,
  input  logic [NUM_BANKS-1:0]                   load_req_i,
  input  logic [NUM_BANKS*DRAM_ADDR_BITWIDTH-1:0] load_base_addr_i,
  input  logic [NUM_BANKS*ADDR_BITWIDTH-1:0]     load_words_i,
  input  logic                                   abort_i,
  output logic [NUM_BANKS-1:0]                   load_ack_o,
  output logic [NUM_BANKS-1:0]                   load_done_o,
  output logic                                   busy_o,
  output logic                                   dram_cmd_valid_o,
  input  logic                                   dram_cmd_ready_i,
  output logic [DRAM_ADDR_BITWIDTH-1:0]          dram_cmd_addr_o,
  output logic [BEAT_BITWIDTH-1:0]               dram_cmd_beats_o,
  input  logic                                   dram_data_valid_i,
  output logic                                   pack_data_valid_o,
  output logic                                   pack_rst_o,
  input  logic                                   pack_we_i,
  output logic [NUM_BANKS-1:0]                   bank_we_o,
  output logic [ADDR_BITWIDTH-1:0]               bank_addr_o
);

  // state  | meaning
  // IDLE   | waiting for a request, arbitration active
  // CLR    | packer cleared, word counter zeroed
  // CMD    | DRAM read command offered
  // STREAM | beats forwarded, packer write edges become bank strobes
  // DONE   | done pulse, trailing beats dropped
  typedef enum logic [2:0] {S_IDLE, S_CLR, S_CMD, S_STREAM, S_DONE} state_t;

  localparam int PTR_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  state_t                        state_q, state_d;
  logic [PTR_W-1:0]              rr_q, rr_d;
  logic [PTR_W-1:0]              grant_q, grant_d;
  logic [DRAM_ADDR_BITWIDTH-1:0] base_q, base_d;
  logic [ADDR_BITWIDTH-1:0]      words_q, words_d;
  logic [ADDR_BITWIDTH-1:0]      cnt_q, cnt_d;
  logic [ADDR_BITWIDTH-1:0]      addr_q, addr_d;
  logic [NUM_BANKS-1:0]          ack_q, ack_d;
  logic                          we_prev_q, we_prev_d;
  logic                          clr_q, clr_d;

  logic [DRAM_ADDR_BITWIDTH-1:0] base_arr [NUM_BANKS];
  logic [ADDR_BITWIDTH-1:0]      words_arr [NUM_BANKS];
  logic [2*NUM_BANKS-1:0]        req_dbl;
  logic                          found;
  logic [PTR_W-1:0]              pick;
  int                            pick_int;
  logic                          we_evt;
  logic                          last_word;
  logic                          stream_evt;

  function automatic logic [NUM_BANKS-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = NUM_BANKS'(1) << idx;
  endfunction

  for (genvar k = 0; k < NUM_BANKS; k++) begin : g_unpack
    assign base_arr[k]  = load_base_addr_i[k*DRAM_ADDR_BITWIDTH +: DRAM_ADDR_BITWIDTH];
    assign words_arr[k] = load_words_i[k*ADDR_BITWIDTH +: ADDR_BITWIDTH];
  end

  // Rotating the doubled request vector puts the pointer position at bit 0.
  assign req_dbl = {load_req_i, load_req_i} >> rr_q;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_int = 0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (!found && req_dbl[i]) begin
        found    = 1'b1;
        pick_int = int'(rr_q) + i;
        if (pick_int >= NUM_BANKS) pick_int = pick_int - NUM_BANKS;
        pick     = PTR_W'(pick_int);
      end
    end
  end

  assign we_evt     = pack_we_i & ~we_prev_q;
  assign stream_evt = (state_q == S_STREAM) & we_evt;
  assign last_word  = (cnt_q == words_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    grant_d   = grant_q;
    base_d    = base_q;
    words_d   = words_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ack_d     = '0;
    clr_d     = 1'b0;
    we_prev_d = pack_we_i;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_CLR;
          grant_d = pick;
          rr_d    = (pick == PTR_W'(NUM_BANKS - 1)) ? '0 : pick + 1'b1;
          base_d  = base_arr[pick];
          words_d = words_arr[pick];
          ack_d   = onehot(pick);
          clr_d   = 1'b1;
        end
      end
      S_CLR: begin
        cnt_d     = '0;
        we_prev_d = 1'b0;
        state_d   = (words_q == '0) ? S_DONE : S_CMD;
      end
      S_CMD: begin
        if (dram_cmd_ready_i) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (we_evt) begin
          addr_d = cnt_q;
          cnt_d  = cnt_q + 1'b1;
          if (last_word) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort wins over every other transition and re-clears the packer.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      clr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge dram_sched_rst_i) begin
    if (dram_sched_rst_i) begin
      state_q   <= S_IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      base_q    <= '0;
      words_q   <= '0;
      cnt_q     <= '0;
      addr_q    <= '0;
      ack_q     <= '0;
      we_prev_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      base_q    <= base_d;
      words_q   <= words_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      we_prev_q <= we_prev_d;
      clr_q     <= clr_d;
    end
  end

  assign load_ack_o        = ack_q;
  assign load_done_o       = (state_q == S_DONE) ? onehot(grant_q) : '0;
  assign busy_o            = (state_q != S_IDLE);
  assign dram_cmd_valid_o  = (state_q == S_CMD);
  assign dram_cmd_addr_o   = base_q;
  assign dram_cmd_beats_o  = BEAT_BITWIDTH'(words_q) * BEAT_BITWIDTH'(BEATS_PER_WORD);
  assign pack_data_valid_o = dram_data_valid_i & (state_q == S_STREAM);
  assign pack_rst_o        = dram_sched_rst_i | clr_q;
  // Strobe and address are combinational so they line up with the packer output word.
  assign bank_we_o         = stream_evt ? onehot(grant_q) : '0;
  assign bank_addr_o       = stream_evt ? cnt_q : addr_q;

endmodule
